// File: rtl/binary_clock_core_if.sv
// ---------------------------------------------------------------------------
// binary_clock_core_if
// Bundles the time-keeping controls, time readout and LED matrix drive of
// binary_clock_core. clk and rst are plain ports on the core, not members here.
//   master : pin wrapper / bench side (drives pps, hours_init, set_*, mode_12h)
//   slave  : the clock core (drives hours, minutes, seconds, d_tick,
//            pps_locked, rows, cols)
// ---------------------------------------------------------------------------
interface binary_clock_core_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic            pps;
  logic [4:0]      hours_init;
  logic            set_en;
  logic [1:0]      set_sel;
  logic            set_inc;
  logic            mode_12h;
  logic [4:0]      hours;
  logic [5:0]      minutes;
  logic [5:0]      seconds;
  logic            d_tick;
  logic            pps_locked;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;

  modport master (
    output pps, hours_init, set_en, set_sel, set_inc, mode_12h,
    input  hours, minutes, seconds, d_tick, pps_locked, rows, cols
  );

  modport slave (
    input  pps, hours_init, set_en, set_sel, set_inc, mode_12h,
    output hours, minutes, seconds, d_tick, pps_locked, rows, cols
  );
endinterface

// File: rtl/binary_clock_core.sv
// ---------------------------------------------------------------------------
// binary_clock_core
// Binary wall clock (hh:mm:ss) with PPS/prescaler second source, field-wise
// time setting, 12/24-hour display and a ROWS x COLS multiplexed LED scanner.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : binary_clock_core_if.slave
//          in : pps (async), hours_init, set_en, set_sel, set_inc, mode_12h
//          out: hours, minutes, seconds, d_tick, pps_locked,
//               rows (active-low one-cold), cols (active-high)
// ---------------------------------------------------------------------------
module binary_clock_core #(
  parameter int TICKS_PER_SEC = 100,
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1
) (
  input logic               clk,
  input logic               rst,
  binary_clock_core_if.slave bus
);

  localparam int NPIX = ROWS * COLS;
  localparam int PW   = $clog2(TICKS_PER_SEC);
  localparam int WW   = $clog2(2 * TICKS_PER_SEC + 1);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(2 * TICKS_PER_SEC);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [SW-1:0] SD_LAST  = SW'(SCAN_DIV - 1);

  // State registers
  logic            pps_s1_q, pps_s1_d;
  logic            pps_s2_q, pps_s2_d;
  logic            pps_prev_q, pps_prev_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            locked_q, locked_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [4:0]      hours_q, hours_d;
  logic [5:0]      minutes_q, minutes_d;
  logic [5:0]      seconds_q, seconds_d;
  logic            d_tick_q, d_tick_d;
  logic            inc_prev_q, inc_prev_d;
  logic [SW-1:0]   sd_q, sd_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [COLS-1:0] cols_q, cols_d;

  // Combinational helpers
  logic            pps_edge;
  logic            pre_wrap;
  logic            sec_pulse;
  logic            inc_edge;
  logic [4:0]      dh;
  logic            pm;
  logic [NPIX-1:0] pix;

  // Display hour: 12-hour mode shows 12 for midnight/noon, 1..11 otherwise.
  always_comb begin
    dh = hours_q;
    pm = 1'b0;
    if (bus.mode_12h) begin
      pm = (hours_q >= 5'd12);
      if (hours_q == 5'd0)
        dh = 5'd12;
      else if (hours_q > 5'd12)
        dh = hours_q - 5'd12;
    end
  end

  // Pixel map: minutes, display hour, pm flag, then seconds if there is
  // room (truncated on small matrices); spare pixels stay dark.
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
      if (gi < 6) begin : g_min
        assign pix[gi] = minutes_q[gi];
      end else if (gi < 11) begin : g_hour
        assign pix[gi] = dh[gi-6];
      end else if (gi == 11) begin : g_pm
        assign pix[gi] = pm;
      end else if (gi < 18) begin : g_sec
        assign pix[gi] = seconds_q[gi-12];
      end else begin : g_off
        assign pix[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    pps_edge  = pps_s2_q & ~pps_prev_q;
    pre_wrap  = (pre_q == PRE_LAST);
    // An edge that arrives while unlocked both locks and counts, and a
    // coincident prescaler wrap merges into the same single pulse.
    sec_pulse = pps_edge | (~locked_q & pre_wrap);
    inc_edge  = bus.set_inc & ~inc_prev_q;

    pps_s1_d   = bus.pps;
    pps_s2_d   = pps_s1_q;
    pps_prev_d = pps_s2_q;
    inc_prev_d = bus.set_inc;

    // Watchdog saturates at its limit so it never wraps back into range.
    if (pps_edge)
      wd_d = '0;
    else if (wd_q != WD_LIMIT)
      wd_d = wd_q + 1'b1;
    else
      wd_d = wd_q;

    if (pps_edge)
      locked_d = 1'b1;
    else if (locked_q && (wd_q == WD_LIMIT))
      locked_d = 1'b0;
    else
      locked_d = locked_q;

    // Held at 0 in set mode so the first tick after leaving it is a full
    // second away; PPS edges re-phase it to the external second.
    if (bus.set_en || pps_edge || pre_wrap)
      pre_d = '0;
    else
      pre_d = pre_q + 1'b1;

    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    d_tick_d  = 1'b0;

    if (bus.set_en) begin
      if (inc_edge) begin
        case (bus.set_sel)
          2'd0:    hours_d   = (hours_q   == 5'd23) ? 5'd0 : hours_q + 5'd1;
          2'd1:    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          2'd2:    seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
          default: seconds_d = 6'd0;
        endcase
      end
    end else if (sec_pulse) begin
      if (seconds_q != 6'd59) begin
        seconds_d = seconds_q + 6'd1;
      end else begin
        seconds_d = 6'd0;
        if (minutes_q != 6'd59) begin
          minutes_d = minutes_q + 6'd1;
        end else begin
          minutes_d = 6'd0;
          if (hours_q != 5'd23) begin
            hours_d = hours_q + 5'd1;
          end else begin
            hours_d  = 5'd0;
            d_tick_d = 1'b1;
          end
        end
      end
    end

    // Row scanner
    if (sd_q == SD_LAST) begin
      sd_d  = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      sd_d  = sd_q + 1'b1;
      row_d = row_q;
    end
    rows_d = ~(ROWS'(1) << row_q);
    cols_d = pix[int'(row_q)*COLS +: COLS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pps_s1_q   <= 1'b0;
      pps_s2_q   <= 1'b0;
      pps_prev_q <= 1'b0;
      wd_q       <= '0;
      locked_q   <= 1'b0;
      pre_q      <= '0;
      hours_q    <= (bus.hours_init >= 5'd24) ? 5'd0 : bus.hours_init;
      minutes_q  <= 6'd0;
      seconds_q  <= 6'd0;
      d_tick_q   <= 1'b0;
      inc_prev_q <= 1'b0;
      sd_q       <= '0;
      row_q      <= '0;
      rows_q     <= '1;
      cols_q     <= '0;
    end else begin
      pps_s1_q   <= pps_s1_d;
      pps_s2_q   <= pps_s2_d;
      pps_prev_q <= pps_prev_d;
      wd_q       <= wd_d;
      locked_q   <= locked_d;
      pre_q      <= pre_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      d_tick_q   <= d_tick_d;
      inc_prev_q <= inc_prev_d;
      sd_q       <= sd_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
    end
  end

  assign bus.hours      = hours_q;
  assign bus.minutes    = minutes_q;
  assign bus.seconds    = seconds_q;
  assign bus.d_tick     = d_tick_q;
  assign bus.pps_locked = locked_q;
  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;

endmodule

// File: tb/tb_binary_clock_core.sv
// ---------------------------------------------------------------------------
// tb_binary_clock_core
// Two cores share clk/rst: u_fast (TICKS_PER_SEC=4, SCAN_DIV=2) exercises
// setting, rollover, 12-hour display and scanning; u_pps (TICKS_PER_SEC=100)
// exercises PPS locking, the watchdog and fallback to the prescaler.
// ---------------------------------------------------------------------------
module tb_binary_clock_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  binary_clock_core_if #(.ROWS(4), .COLS(4)) bf ();
  binary_clock_core_if #(.ROWS(4), .COLS(4)) bp ();

  binary_clock_core #(.TICKS_PER_SEC(4), .ROWS(4), .COLS(4), .SCAN_DIV(2)) u_fast (
    .clk(clk), .rst(rst), .bus(bf)
  );
  binary_clock_core #(.TICKS_PER_SEC(100), .ROWS(4), .COLS(4), .SCAN_DIV(1)) u_pps (
    .clk(clk), .rst(rst), .bus(bp)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int dtick_cnt = 0;

  always @(negedge clk) if (bf.d_tick === 1'b1) dtick_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
      return;
    end
    it = sb_q.pop_front();
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
    end
    $display("check %-16s observed %0d expected %0d", it.tag, obs, it.exp);
  endtask

  task automatic pulse_inc(input logic [1:0] sel, input int n);
    bf.set_sel = sel;
    repeat (n) begin
      bf.set_inc = 1'b1;
      tick(1);
      bf.set_inc = 1'b0;
      tick(1);
    end
  endtask

  task automatic wait_row(input logic [3:0] target, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bf.rows === target) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Reads the display hour and pm flag back out of the scanned columns.
  task automatic read_disp(input logic [4:0] exp_dh, input logic exp_pm);
    logic       f1, f2;
    logic [3:0] c1, c2;
    tick(2);
    push("row1_seen", 1);
    wait_row(4'b1101, f1);
    c1 = bf.cols;
    check(32'(f1));
    push("row2_seen", 1);
    wait_row(4'b1011, f2);
    c2 = bf.cols;
    check(32'(f2));
    push("disp_hour", 32'(exp_dh));
    check(32'({c2[2:0], c1[3:2]}));
    push("disp_pm", 32'(exp_pm));
    check(32'(c2[3]));
  endtask

  initial begin
    logic       found;
    logic [3:0] prev_rows;
    logic [3:0] exp_rows [8];
    logic [3:0] exp_cols [8];
    int         sec_model;

    bf.pps = 1'b0; bf.hours_init = 5'd5; bf.set_en = 1'b0;
    bf.set_sel = 2'd0; bf.set_inc = 1'b0; bf.mode_12h = 1'b0;
    bp.pps = 1'b0; bp.hours_init = 5'd5; bp.set_en = 1'b1;
    bp.set_sel = 2'd0; bp.set_inc = 1'b0; bp.mode_12h = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(2);
    push("rst_hours", 5);       check(32'(bf.hours));
    push("rst_minutes", 0);     check(32'(bf.minutes));
    push("rst_seconds", 0);     check(32'(bf.seconds));
    push("rst_rows", 4'hF);     check(32'(bf.rows));
    push("rst_cols", 0);        check(32'(bf.cols));
    push("rst_locked", 0);      check(32'(bf.pps_locked));
    push("rst_dtick", 0);       check(32'(bf.d_tick));
    push("rst_hours_pps", 5);   check(32'(bp.hours));
    bf.hours_init = 5'd30;
    tick(1);
    push("rst_hours_30", 0);    check(32'(bf.hours));

    // First row drive appears the cycle after reset is released
    bf.set_en = 1'b1;
    rst = 1'b0;
    push("first_row", 4'b1110);
    tick(1);
    check(32'(bf.rows));

    // Field setting: wrap without carry, level-held inc counts once, clear
    pulse_inc(2'd0, 23);
    push("set_hours_23", 23);   check(32'(bf.hours));
    pulse_inc(2'd1, 59);
    push("set_min_59", 59);     check(32'(bf.minutes));
    pulse_inc(2'd1, 3);
    push("set_min_wrap", 2);    check(32'(bf.minutes));
    push("set_no_carry", 23);   check(32'(bf.hours));
    bf.set_inc = 1'b1;
    tick(10);
    bf.set_inc = 1'b0;
    tick(1);
    push("set_held_once", 3);   check(32'(bf.minutes));
    pulse_inc(2'd2, 5);
    push("set_sec_5", 5);       check(32'(bf.seconds));
    pulse_inc(2'd3, 1);
    push("set_sec_clear", 0);   check(32'(bf.seconds));

    // Preload 23:59:58 and run off the prescaler through midnight
    pulse_inc(2'd1, 56);
    pulse_inc(2'd2, 58);
    push("pre_min", 59);        check(32'(bf.minutes));
    push("pre_sec", 58);        check(32'(bf.seconds));
    push("no_dtick_set", 0);    check(32'(dtick_cnt));
    bf.set_en = 1'b0;
    tick(3);
    push("sec_hold_3cyc", 58);  check(32'(bf.seconds));
    tick(1);
    push("sec_first_tick", 59); check(32'(bf.seconds));
    tick(4);
    push("wrap_hours", 0);      check(32'(bf.hours));
    push("wrap_minutes", 0);    check(32'(bf.minutes));
    push("wrap_seconds", 0);    check(32'(bf.seconds));
    push("dtick_high", 1);      check(32'(bf.d_tick));
    tick(1);
    push("dtick_low", 0);       check(32'(bf.d_tick));
    push("dtick_count", 1);     check(32'(dtick_cnt));
    bf.set_en = 1'b1;
    tick(5);
    push("frozen_sec", 0);      check(32'(bf.seconds));

    // 10:37:00 scan pattern
    pulse_inc(2'd0, 10);
    pulse_inc(2'd1, 37);
    exp_rows = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    exp_cols = '{4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    push("scan_sync", 1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev_rows = bf.rows;
      tick(1);
      if (bf.rows === 4'b1110 && prev_rows !== 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    check(32'(found));
    for (int i = 0; i < 8; i++) begin
      push($sformatf("scan_rows_%0d", i), 32'(exp_rows[i]));
      push($sformatf("scan_cols_%0d", i), 32'(exp_cols[i]));
    end
    for (int i = 0; i < 8; i++) begin
      check(32'(bf.rows));
      check(32'(bf.cols));
      tick(1);
    end

    // 12-hour display
    bf.mode_12h = 1'b1;
    read_disp(5'd10, 1'b0);
    pulse_inc(2'd0, 2);
    read_disp(5'd12, 1'b1);
    pulse_inc(2'd0, 1);
    read_disp(5'd1, 1'b1);
    bf.mode_12h = 1'b0;
    read_disp(5'd13, 1'b0);
    bf.mode_12h = 1'b1;
    pulse_inc(2'd0, 11);
    read_disp(5'd12, 1'b0);
    push("dtick_count_end", 1); check(32'(dtick_cnt));

    // PPS: lock and count one second per edge
    sec_model = 0;
    bp.set_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bp.pps = 1'b1;
      sec_model++;
      push($sformatf("pps_sec_%0d", k), 32'(sec_model));
      push($sformatf("pps_lock_%0d", k), 1);
      tick(2);
      bp.pps = 1'b0;
      tick(8);
      check(32'(bp.seconds));
      check(32'(bp.pps_locked));
    end

    // PPS stops: watchdog drops lock, then prescaler takes over
    tick(190);
    push("lock_held", 1);       check(32'(bp.pps_locked));
    push("sec_while_lock", 5);  check(32'(bp.seconds));
    tick(6);
    push("lock_lost", 0);       check(32'(bp.pps_locked));
    push("sec_after_loss", 5);  check(32'(bp.seconds));
    push("fallback_seen", 1);
    found = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (bp.seconds !== 6'd5) begin
        found = 1'b1;
        break;
      end
    end
    check(32'(found));
    push("fallback_sec_6", 6);  check(32'(bp.seconds));
    tick(99);
    push("fallback_hold", 6);   check(32'(bp.seconds));
    tick(1);
    push("fallback_sec_7", 7);  check(32'(bp.seconds));
    push("pps_hours", 5);       check(32'(bp.hours));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
